// File: rtl/task_ready_arbiter.sv
// Ready-task arbiter: tracks per-slot ready flags and priorities, and uses a sequential scan
// to publish the highest ready priority, its lowest-ID task and the round-robin successor.
module task_ready_arbiter #(
  parameter int NTASK = 8,
  parameter int PRIW  = 6
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            tick_in,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [7:0]      cmd_task,
  input  logic [PRIW-1:0] cmd_pri,
  output logic [PRIW-1:0] highpriority_out,
  output logic [7:0]      ptr_hpritask_out,
  output logic [7:0]      ptr_nexttask_out,
  output logic            any_ready_out,
  output logic            cmd_err_out
);

  localparam int IW = (NTASK > 1) ? $clog2(NTASK) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, SCAN, DONE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_READY, OP_BLOCK, OP_SETPRI} op_t;

  state_t state, state_n;

  logic [NTASK-1:0]           ready;
  logic [NTASK-1:0][PRIW-1:0] pri;
  logic [7:0]                 rr_ptr;
  logic                       tick_prev, tick_pend;

  op_t             op_q;
  logic [7:0]      task_q;
  logic [PRIW-1:0] pri_q;

  logic [IW-1:0]   scan_idx;
  logic            found_q, nx_found_q;
  logic [PRIW-1:0] max_q;
  logic [7:0]      hp_id_q, nx_id_q;

  logic          cap, tick_start, scan_init, apply_en, done;
  logic          task_ok, scan_last, tick_rise;
  logic [IW-1:0] task_idx;
  logic [7:0]    scan_id;

  assign task_ok   = task_q < 8'(NTASK);
  assign task_idx  = task_q[IW-1:0];
  assign scan_last = scan_idx == IW'(NTASK - 1);
  assign scan_id   = 8'(scan_idx);
  assign tick_rise = tick_in & ~tick_prev;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cmd_ready   = 1'b0;
    cmd_err_out = 1'b0;
    cap         = 1'b0;
    tick_start  = 1'b0;
    scan_init   = 1'b0;
    apply_en    = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cap     = 1'b1;
          state_n = APPLY;
        end else if (tick_pend) begin
          tick_start = 1'b1;
          scan_init  = 1'b1;
          state_n    = SCAN;
        end
      end
      APPLY: begin
        if (!task_ok) begin
          cmd_err_out = 1'b1;
          state_n     = IDLE;
        end else begin
          apply_en  = 1'b1;
          scan_init = 1'b1;
          state_n   = SCAN;
        end
      end
      SCAN: if (scan_last) state_n = DONE;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ready            <= '0;
      pri              <= '0;
      rr_ptr           <= '0;
      tick_prev        <= 1'b0;
      tick_pend        <= 1'b0;
      op_q             <= OP_NOP;
      task_q           <= '0;
      pri_q            <= '0;
      scan_idx         <= '0;
      found_q          <= 1'b0;
      nx_found_q       <= 1'b0;
      max_q            <= '0;
      hp_id_q          <= '0;
      nx_id_q          <= '0;
      highpriority_out <= '0;
      ptr_hpritask_out <= '0;
      ptr_nexttask_out <= '0;
      any_ready_out    <= 1'b0;
    end else begin
      tick_prev <= tick_in;
      // A new rising edge in the service cycle survives the clear
      tick_pend <= (tick_pend & ~tick_start) | tick_rise;

      if (cap) begin
        op_q   <= op_t'(cmd_op);
        task_q <= cmd_task;
        pri_q  <= cmd_pri;
      end

      if (apply_en) begin
        case (op_q)
          OP_READY:  ready[task_idx] <= 1'b1;
          OP_BLOCK:  ready[task_idx] <= 1'b0;
          OP_SETPRI: pri[task_idx]   <= pri_q;
          default:   ;
        endcase
      end

      if (tick_start) rr_ptr <= ptr_nexttask_out;

      if (scan_init) begin
        scan_idx   <= '0;
        found_q    <= 1'b0;
        nx_found_q <= 1'b0;
        max_q      <= '0;
        hp_id_q    <= '0;
        nx_id_q    <= '0;
      end else if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        if (ready[scan_idx]) begin
          // Ascending scan: first slot at a new max is the lowest ID at that max
          if (!found_q || pri[scan_idx] > max_q) begin
            found_q    <= 1'b1;
            max_q      <= pri[scan_idx];
            hp_id_q    <= scan_id;
            nx_found_q <= scan_id > rr_ptr;
            nx_id_q    <= scan_id;
          end else if (pri[scan_idx] == max_q && !nx_found_q && scan_id > rr_ptr) begin
            nx_found_q <= 1'b1;
            nx_id_q    <= scan_id;
          end
        end
      end

      if (done) begin
        highpriority_out <= max_q;
        ptr_hpritask_out <= hp_id_q;
        ptr_nexttask_out <= nx_found_q ? nx_id_q : hp_id_q;
        any_ready_out    <= found_q;
      end
    end
  end

endmodule

// File: tb/tb_task_ready_arbiter.sv
// Scoreboard bench for task_ready_arbiter: directed commands/ticks push expected results,
// and a monitor checks them each time the arbiter returns to accepting commands.
module tb_task_ready_arbiter;

  localparam int N = 8;
  localparam int P = 6;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         tick_in = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [7:0]   cmd_task = '0;
  logic [P-1:0] cmd_pri = '0;
  logic [P-1:0] highpriority_out;
  logic [7:0]   ptr_hpritask_out;
  logic [7:0]   ptr_nexttask_out;
  logic         any_ready_out;
  logic         cmd_err_out;

  task_ready_arbiter #(.NTASK(N), .PRIW(P)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .tick_in          (tick_in),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_task         (cmd_task),
    .cmd_pri          (cmd_pri),
    .highpriority_out (highpriority_out),
    .ptr_hpritask_out (ptr_hpritask_out),
    .ptr_nexttask_out (ptr_nexttask_out),
    .any_ready_out    (any_ready_out),
    .cmd_err_out      (cmd_err_out)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    string name;
    int    hp, hpt, nxt, any, err, busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: an operation completes when cmd_ready returns high
  int   busy_cnt = 0;
  int   err_cnt  = 0;
  logic prev_ready = 1'b1;
  always @(negedge aclk) begin
    if (mon_en) begin
      if (!cmd_ready)  busy_cnt++;
      if (cmd_err_out) err_cnt++;
      if (cmd_ready && !prev_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_completion: got completion expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, ".highpriority"}, int'(highpriority_out), e.hp);
          chk({e.name, ".hpritask"},     int'(ptr_hpritask_out), e.hpt);
          chk({e.name, ".nexttask"},     int'(ptr_nexttask_out), e.nxt);
          chk({e.name, ".any_ready"},    int'(any_ready_out),    e.any);
          chk({e.name, ".err_pulses"},   err_cnt,                e.err);
          if (e.busy != 0) chk({e.name, ".busy_cycles"}, busy_cnt, e.busy);
        end
        busy_cnt = 0;
        err_cnt  = 0;
      end
      prev_ready = cmd_ready;
    end
  end

  task automatic expect_op(input string nm, input int hp, input int hpt, input int nxt,
                           input int any, input int err, input int busy);
    exp_t e;
    e.name = nm; e.hp = hp; e.hpt = hpt; e.nxt = nxt; e.any = any; e.err = err; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input int t, input int p);
    int i;
    @(negedge aclk);
    for (i = 0; i < 200 && !cmd_ready; i++) @(negedge aclk);
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL issue_timeout: got cmd_ready=0 expected 1");
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_task  = 8'(t);
    cmd_pri   = P'(p);
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 10 && cmd_ready; i++) @(negedge aclk);
    for (i = 0; i < 200 && !cmd_ready; i++) @(negedge aclk);
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL done_timeout: got cmd_ready=0 expected 1");
    end
  endtask

  task automatic pulse_tick();
    @(negedge aclk) tick_in = 1'b1;
    @(negedge aclk) tick_in = 1'b0;
  endtask

  task automatic op_full(input string nm, input logic [1:0] op, input int t, input int p,
                         input int hp, input int hpt, input int nxt, input int any);
    expect_op(nm, hp, hpt, nxt, any, 0, N + 2);
    issue(op, t, p);
    wait_done();
  endtask

  localparam logic [1:0] NOP = 2'b00, RDY = 2'b01, BLK = 2'b10, SETP = 2'b11;

  initial begin
    repeat (3) @(negedge aclk);
    chk("reset.cmd_ready",    int'(cmd_ready),        1);
    chk("reset.highpriority", int'(highpriority_out), 0);
    chk("reset.hpritask",     int'(ptr_hpritask_out), 0);
    chk("reset.nexttask",     int'(ptr_nexttask_out), 0);
    chk("reset.any_ready",    int'(any_ready_out),    0);
    chk("reset.cmd_err",      int'(cmd_err_out),      0);
    aresetn = 1'b1;
    mon_en  = 1'b1;

    op_full("setpri_t3", SETP, 3, 5, 0, 0, 0, 0);
    op_full("ready_t3",  RDY,  3, 0, 5, 3, 3, 1);

    expect_op("bad_task9", 5, 3, 3, 1, 1, 1);
    issue(RDY, 9, 0);
    wait_done();

    op_full("block_t3",  BLK, 3, 0, 0, 0, 0, 0);
    op_full("ready_t0_pri0", RDY, 0, 0, 0, 0, 0, 1);
    op_full("block_t0",  BLK, 0, 0, 0, 0, 0, 0);

    op_full("setpri_t1", SETP, 1, 7, 0, 0, 0, 0);
    op_full("setpri_t4", SETP, 4, 7, 0, 0, 0, 0);
    op_full("setpri_t6", SETP, 6, 7, 0, 0, 0, 0);
    op_full("ready_t1",  RDY,  1, 0, 7, 1, 1, 1);
    op_full("ready_t4",  RDY,  4, 0, 7, 1, 1, 1);
    op_full("ready_t6",  RDY,  6, 0, 7, 1, 1, 1);
    op_full("ready_t3_low", RDY, 3, 0, 7, 1, 1, 1);

    expect_op("tick1", 7, 1, 4, 1, 0, N + 1); pulse_tick(); wait_done();
    expect_op("tick2", 7, 1, 6, 1, 0, N + 1); pulse_tick(); wait_done();
    expect_op("tick3_wrap", 7, 1, 1, 1, 0, N + 1); pulse_tick(); wait_done();

    // Two ticks during a command scan collapse into one advance afterwards
    expect_op("nop_with_ticks", 7, 1, 1, 1, 0, N + 2);
    expect_op("coalesced_tick", 7, 1, 4, 1, 0, N + 1);
    issue(NOP, 2, 0);
    repeat (3) @(negedge aclk);
    tick_in = 1'b1;
    @(negedge aclk) tick_in = 1'b0;
    @(negedge aclk) tick_in = 1'b1;
    @(negedge aclk) tick_in = 1'b0;
    wait_done();
    wait_done();
    repeat (30) @(negedge aclk);
    chk("coalesce.queue_empty", sb.size(), 0);

    // Reset in the middle of a scan
    expect_op("reset_mid_scan", 0, 0, 0, 0, 0, 0);
    issue(RDY, 2, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midreset.cmd_ready", int'(cmd_ready), 1);
    aresetn = 1'b1;

    op_full("ready_t2_after_reset", RDY, 2, 0, 0, 2, 2, 1);
    op_full("block_t2",  BLK, 2, 0, 0, 0, 0, 0);
    op_full("setpri_t7_max", SETP, 7, 63, 0, 0, 0, 0);
    op_full("ready_t7",  RDY, 7, 0, 63, 7, 7, 1);
    expect_op("tick_single_self", 63, 7, 7, 1, 0, N + 1); pulse_tick(); wait_done();

    repeat (5) @(negedge aclk);
    chk("final.queue_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/task_ready_arbiter.md
TASK_READY_ARBITER -- requirements
Module: task_ready_arbiter

Interface
REQ-001 SHALL have parameter NTASK, default 8: number of task slots, IDs 0..NTASK-1, range 2..64.
REQ-002 SHALL have parameter PRIW, default 6: priority width; a larger value means a higher priority.
REQ-003 SHALL have port aclk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port tick_in  in  1  RTOS time-slice tick, level, sampled each cycle.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accept; transfer on cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_op  in  2  opcode: 00 NOP, 01 READY, 10 BLOCK, 11 SETPRI.
REQ-009 SHALL have port cmd_task  in  8  target task ID.
REQ-010 SHALL have port cmd_pri  in  PRIW  priority for SETPRI.
REQ-011 SHALL have port highpriority_out  out  PRIW  highest ready priority.
REQ-012 SHALL have port ptr_hpritask_out  out  8  lowest-ID ready task at that priority.
REQ-013 SHALL have port ptr_nexttask_out  out  8  round-robin successor at that priority.
REQ-014 SHALL have port any_ready_out  out  1  at least one task ready.
REQ-015 SHALL have port cmd_err_out  out  1  one-cycle pulse for a rejected command.

Function
REQ-016 SHALL keep per slot a ready flag, a PRIW-bit priority and an 8-bit round-robin pointer rr_ptr.
REQ-017 SHALL run FSM IDLE -> APPLY -> SCAN -> DONE -> IDLE; cmd_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE, on an accepted command go to APPLY and capture op, task and pri.
REQ-019 SHALL, in IDLE with no accepted command and tick_pend=1, set rr_ptr=ptr_nexttask_out, clear tick_pend and go to SCAN.
REQ-020 SHALL, when a command and tick_pend coincide in IDLE, service the command first; the tick stays pending.
REQ-021 SHALL, in APPLY: READY sets ready[task]; BLOCK clears ready[task]; SETPRI writes pri[task]; NOP changes nothing; then go to SCAN.
REQ-022 SHALL, if cmd_task >= NTASK, pulse cmd_err_out in APPLY, change no state and return to IDLE without a scan.
REQ-023 SHALL examine one slot per cycle in SCAN, index 0..NTASK-1; scan time is exactly NTASK cycles.
REQ-024 SHALL, during SCAN, track max ready priority, lowest ID at that max, and the first ID > rr_ptr at that max.
REQ-025 SHALL pick nexttask as first ID > rr_ptr at max, else wrap to the lowest ID at max.
REQ-026 SHALL, in DONE, register all four result outputs together, then go to IDLE.
REQ-027 SHALL hold outputs stable in every other state; from accept edge, outputs update NTASK+2 edges later.
REQ-028 SHALL, when no task is ready, drive highpriority_out=0, both pointers 0 and any_ready_out=0.
REQ-029 SHALL, when a ready task holds priority 0, drive any_ready_out=1 and distinguish it from the empty case only by that flag.
REQ-030 SHALL detect a tick as a rising edge of tick_in (registered previous value) and set tick_pend in any state.
REQ-031 SHALL coalesce several ticks received while busy into one pending tick.
REQ-032 SHALL leave a single ready task at max priority as its own successor: nexttask = hpritask.

Reset
REQ-033 SHALL, while aresetn=0 at a clock edge, clear all ready flags, priorities, rr_ptr, tick_pend and the tick history, and enter IDLE.
REQ-034 SHALL hold outputs after reset at highpriority_out=0, pointers 0, any_ready_out=0, cmd_err_out=0, cmd_ready=1.
REQ-035 SHALL abort any APPLY/SCAN/DONE on reset mid-operation and not update outputs.

Verification
REQ-036 SHALL test: SETPRI t3=5, then READY t3 -> after the scan, highpriority_out=5, ptr_hpritask_out=3, ptr_nexttask_out=3, any_ready_out=1.
REQ-037 SHALL test: t1,t4,t6 ready at pri 7, rr_ptr=0 -> next=1; three ticks, each serviced -> next 4, 6, then wraps to 1.
REQ-038 SHALL test: BLOCK the only ready task -> all outputs 0, any_ready_out=0.
REQ-039 SHALL test: READY with cmd_task=9 (NTASK=8) -> one cmd_err_out pulse, no output change, cmd_ready back next cycle.
REQ-040 SHALL test: tick rises during SCAN of a command plus a second tick before DONE -> exactly one rr advance after the command scan.
REQ-041 SHALL test: aresetn=0 mid-SCAN -> next cycle IDLE, cmd_ready=1, outputs at reset values.
